// File: rtl/patdet_pkg.sv
// Shared types and constants for the pattern-detector scheduler.
// Holds the one-hot FSM encoding, the detected pattern and a width helper.
package patdet_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_CLR   = 4'b0010,
    S_SHIFT = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  localparam logic [3:0] PATTERN = 4'b1101;

  // Ceiling log2, but never below 1, so that index vectors always have a bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/patdet_sched_det.sv
// Bit-serial Mealy detector for PATTERN (overlapping, MSB first).
// The match output is combinational from din in the cycle the last bit is presented.
module pat_det
  import patdet_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic din,
  input  logic valid_i,
  output logic pat_det_o
);

  logic [2:0] hist;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist <= '0;
    end else if (valid_i) begin
      hist <= {hist[1:0], din};
    end
  end

  assign pat_det_o = valid_i && ({hist, din} == PATTERN);

endmodule

// File: rtl/patdet_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
// The caller registers the grant.
module rr_arbiter
  import patdet_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] pointer,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] index
);

  logic             hi_found;
  logic             lo_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Descending scan: the last hit written is the lowest index in each class.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
        if (i >= int'(pointer)) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    index = hi_found ? hi_idx : lo_idx;
    if (enable && lo_found) begin
      grant = N_REQ'(1) << index;
    end
  end

endmodule

// File: rtl/patdet_sched.sv
// Round-robin scheduler sharing one serial 1101 detector among N_REQ requesters.
// Each grant clears the detector, shifts one word through it and reports the match count.
//
// state   | meaning
// S_IDLE  | arbitrate; on a request capture the word and register the grant
// S_CLR   | one cycle holding the detector in reset
// S_SHIFT | W cycles presenting shreg MSB first, counting match pulses
// S_DONE  | done pulse visible, grant drops, pointer advances
module patdet_sched
  import patdet_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int W     = 8,
  localparam int CNT_W = clog2(W + 1),
  localparam int IDX_W = clog2(N_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [N_REQ*W-1:0]   data_i,
  output logic [N_REQ-1:0]     gnt_o,
  output logic                 done_o,
  output logic [IDX_W-1:0]     done_id_o,
  output logic [CNT_W-1:0]     match_cnt_o,
  output logic                 det_rst_o,
  output logic                 det_din_o,
  output logic                 det_valid_o,
  input  logic                 det_pat_i
);

  localparam int BIT_W = clog2(W);

  state_t           state;
  logic [W-1:0]     shreg;
  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (req_i),
    .pointer (rr_ptr),
    .enable  (state == S_IDLE),
    .grant   (arb_gnt),
    .index   (arb_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      gnt_o       <= '0;
      gnt_idx     <= '0;
      done_o      <= 1'b0;
      done_id_o   <= '0;
      match_cnt_o <= '0;
      rr_ptr      <= '0;
      shreg       <= '0;
      cnt         <= '0;
      bit_cnt     <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (|req_i) begin
            gnt_o   <= arb_gnt;
            gnt_idx <= arb_idx;
            shreg   <= data_i[int'(arb_idx)*W +: W];
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= S_CLR;
          end
        end
        S_CLR: begin
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          shreg   <= {shreg[W-2:0], 1'b0};
          bit_cnt <= bit_cnt + BIT_W'(1);
          if (det_pat_i) begin
            cnt <= cnt + CNT_W'(1);
          end
          // The last bit's match is folded in directly so the result is ready with done.
          if (bit_cnt == BIT_W'(W - 1)) begin
            state       <= S_DONE;
            done_o      <= 1'b1;
            done_id_o   <= gnt_idx;
            match_cnt_o <= cnt + CNT_W'(det_pat_i);
          end
        end
        S_DONE: begin
          gnt_o  <= '0;
          rr_ptr <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          gnt_o <= '0;
        end
      endcase
    end
  end

  assign det_rst_o   = rst_i || (state == S_CLR);
  assign det_valid_o = (state == S_SHIFT);
  assign det_din_o   = (state == S_SHIFT) && shreg[W-1];

endmodule

// File: tb/tb_patdet_sched.sv
// Directed bench for patdet_sched wired to the pat_det detector.
// A second instance with W=16 covers the wide maximum-overlap word.
module tb_patdet_sched;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int W2 = 16;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   gnt_o;
  logic           done_o;
  logic [1:0]     done_id_o;
  logic [3:0]     match_cnt_o;
  logic           det_rst, det_din, det_valid, det_pat;

  logic [N-1:0]    req16;
  logic [N*W2-1:0] data16;
  logic [N-1:0]    gnt16;
  logic            done16;
  logic [1:0]      id16;
  logic [4:0]      cnt16;
  logic            det_rst16, det_din16, det_valid16, det_pat16;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  patdet_sched #(.N_REQ(N), .W(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .data_i(data_i),
    .gnt_o(gnt_o), .done_o(done_o), .done_id_o(done_id_o), .match_cnt_o(match_cnt_o),
    .det_rst_o(det_rst), .det_din_o(det_din), .det_valid_o(det_valid), .det_pat_i(det_pat)
  );

  pat_det u_det (
    .clk_i(clk_i), .rst_i(det_rst), .din(det_din), .valid_i(det_valid), .pat_det_o(det_pat)
  );

  patdet_sched #(.N_REQ(N), .W(W2)) dut16 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req16), .data_i(data16),
    .gnt_o(gnt16), .done_o(done16), .done_id_o(id16), .match_cnt_o(cnt16),
    .det_rst_o(det_rst16), .det_din_o(det_din16), .det_valid_o(det_valid16), .det_pat_i(det_pat16)
  );

  pat_det u_det16 (
    .clk_i(clk_i), .rst_i(det_rst16), .din(det_din16), .valid_i(det_valid16), .pat_det_o(det_pat16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_count(input logic [W-1:0] word);
    int c;
    c = 0;
    for (int i = W - 1; i >= 3; i--) begin
      if (word[i -: 4] == 4'b1101) c++;
    end
    return c;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Single transaction from an idle scheduler, checked cycle by cycle.
  task automatic run_one(input int k, input logic [W-1:0] word, input int exp_cnt, input string tag);
    req_i[k] = 1'b1;
    data_i[k*W +: W] = word;
    for (int n = 1; n <= W + 2; n++) begin
      step();
      chk({tag, "_gnt"}, gnt_o, 32'(1 << k));
      chk({tag, "_done"}, done_o, (n == W + 2));
      if (n == 1) chk({tag, "_detrst"}, det_rst, 1);
      if (n >= 2 && n <= W + 1) begin
        chk({tag, "_valid"}, det_valid, 1);
        chk({tag, "_din"}, det_din, word[W-1-(n-2)]);
      end
    end
    chk({tag, "_id"}, done_id_o, k);
    chk({tag, "_cnt"}, match_cnt_o, exp_cnt);
    req_i[k] = 1'b0;
    step();
    chk({tag, "_gnt_off"}, gnt_o, 0);
    chk({tag, "_done_off"}, done_o, 0);
    chk({tag, "_cnt_held"}, match_cnt_o, exp_cnt);
    chk({tag, "_valid_off"}, det_valid, 0);
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
      chk("gnt_onehot", $onehot0(gnt_o), 1);
    end while (!done_o && cycles < budget);
    chk("done_seen", done_o, 1);
  endtask

  initial begin
    int cyc;
    int exp_ids[5];
    logic [W-1:0] w;
    int k;

    rst_i  = 1'b1;
    req_i  = '0;
    data_i = '0;
    req16  = '0;
    data16 = '0;
    step();
    step();
    chk("rst_gnt", gnt_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_id", done_id_o, 0);
    chk("rst_cnt", match_cnt_o, 0);
    chk("rst_valid", det_valid, 0);
    chk("rst_din", det_din, 0);
    chk("rst_detrst", det_rst, 1);
    rst_i = 1'b0;
    #1;
    chk("idle_detrst", det_rst, 0);

    run_one(0, 8'hDA, 2, "single_da");
    run_one(2, 8'hFF, 0, "nomatch_ff");
    run_one(2, 8'h00, 0, "nomatch_00");
    run_one(1, 8'hDB, 2, "overlap_db");
    run_one(3, 8'h0D, 1, "tail_0d");

    req16[0] = 1'b1;
    data16[W2-1:0] = 16'hDB6D;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!done16 && cyc < 40);
    chk("w16_done", done16, 1);
    chk("w16_lat", cyc, W2 + 2);
    chk("w16_cnt", cnt16, 5);
    chk("w16_id", id16, 0);
    req16 = '0;
    step();

    // Request drops and word changes mid-shift; the captured word is still counted.
    req_i[3] = 1'b1;
    data_i[3*W +: W] = 8'hDA;
    for (int n = 1; n <= W + 2; n++) begin
      step();
      if (n == 5) begin
        req_i[3] = 1'b0;
        data_i[3*W +: W] = 8'hFF;
      end
    end
    chk("robust_done", done_o, 1);
    chk("robust_gnt", gnt_o, 4'b1000);
    chk("robust_id", done_id_o, 3);
    chk("robust_cnt", match_cnt_o, 2);
    step();

    rst_i = 1'b1;
    req_i = 4'hF;
    data_i = {8'h0D, 8'hDB, 8'hFF, 8'hDA};
    step();
    rst_i = 1'b0;
    exp_ids = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      wait_done(2 * (W + 3), cyc);
      chk("rr_id", done_id_o, exp_ids[i]);
      chk("rr_cnt", match_cnt_o, ref_count(data_i[exp_ids[i]*W +: W]));
      chk("rr_spacing", cyc, (i == 0) ? W + 2 : W + 3);
      if (i == 4) req_i = '0;
    end
    step();

    // Abort: pointer is 1 now, so req1 wins; after reset the pointer restarts at 0.
    req_i = 4'b0011;
    data_i[0 +: W] = 8'hFF;
    data_i[W +: W] = 8'hDA;
    for (int n = 1; n <= 4; n++) begin
      step();
      if (n == 1) chk("abort_gnt", gnt_o, 4'b0010);
    end
    rst_i = 1'b1;
    #1;
    chk("abort_detrst", det_rst, 1);
    chk("abort_done_during", done_o, 0);
    step();
    chk("abort_gnt_off", gnt_o, 0);
    chk("abort_valid_off", det_valid, 0);
    chk("abort_done_off", done_o, 0);
    rst_i = 1'b0;
    wait_done(W + 4, cyc);
    chk("reserve_first_id", done_id_o, 0);
    chk("reserve_first_cnt", match_cnt_o, 0);
    req_i = 4'b0010;
    wait_done(W + 4, cyc);
    chk("reserve_second_id", done_id_o, 1);
    chk("reserve_second_cnt", match_cnt_o, 2);
    req_i = '0;
    step();

    for (int i = 0; i < 500; i++) begin
      k = int'($urandom_range(0, N - 1));
      w = W'($urandom);
      req_i[k] = 1'b1;
      data_i[k*W +: W] = w;
      wait_done(W + 4, cyc);
      chk("rand_id", done_id_o, k);
      chk("rand_cnt", match_cnt_o, ref_count(w));
      req_i[k] = 1'b0;
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
